// File: rtl/udp_ack_responder.sv
//------------------------------------------------------------------------------
// udp_ack_responder
// Emits a three-word UDP acknowledge (MAGIC, {frame_id,status}, {0,seq}) per
// request, with a one-entry pending slot and a saturating drop counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module udp_ack_responder #(
    parameter logic [15:0] LOCAL_PORT = 16'd26177,
    parameter logic [31:0] MAGIC      = 32'h4C454441
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_ip,
    input  logic [15:0] req_port,
    input  logic [15:0] req_frame_id,
    input  logic [15:0] req_status,
    output logic        udp_sink_valid,
    output logic        udp_sink_last,
    input  logic        udp_sink_ready,
    output logic [15:0] udp_sink_src_port,
    output logic [15:0] udp_sink_dst_port,
    output logic [31:0] udp_sink_ip_address,
    output logic [15:0] udp_sink_length,
    output logic [31:0] udp_sink_data,
    output logic [3:0]  udp_sink_error,
    output logic [15:0] drop_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic        r_last;
    logic [31:0] r_data;
    logic [31:0] r_ip;
    logic [15:0] r_dst_port;
    logic [15:0] r_id;
    logic [15:0] r_status;
    logic        r_pend_valid;
    logic [31:0] r_pend_ip;
    logic [15:0] r_pend_port;
    logic [15:0] r_pend_id;
    logic [15:0] r_pend_status;
    logic [15:0] r_seq;
    logic [15:0] r_drop_count;

    logic w_xfer;
    logic w_w2_done;
    logic w_free;

    assign w_xfer    = r_valid & udp_sink_ready;
    assign w_w2_done = (r_state == ST_W2) & w_xfer;
    // A new packet may start only from IDLE or on the cycle the last word leaves
    assign w_free    = (r_state == ST_IDLE) | w_w2_done;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_data        <= 32'd0;
            r_ip          <= 32'd0;
            r_dst_port    <= 16'd0;
            r_id          <= 16'd0;
            r_status      <= 16'd0;
            r_pend_valid  <= 1'b0;
            r_pend_ip     <= 32'd0;
            r_pend_port   <= 16'd0;
            r_pend_id     <= 16'd0;
            r_pend_status <= 16'd0;
            r_seq         <= 16'd0;
            r_drop_count  <= 16'd0;
        end else begin
            if (w_w2_done) begin
                r_seq <= r_seq + 16'd1;
            end
            if (w_free) begin
                if (r_pend_valid) begin
                    r_state    <= ST_W0;
                    r_valid    <= 1'b1;
                    r_last     <= 1'b0;
                    r_data     <= MAGIC;
                    r_ip       <= r_pend_ip;
                    r_dst_port <= r_pend_port;
                    r_id       <= r_pend_id;
                    r_status   <= r_pend_status;
                    // A coinciding request refills the slot instead of dropping
                    if (req_valid) begin
                        r_pend_ip     <= req_ip;
                        r_pend_port   <= req_port;
                        r_pend_id     <= req_frame_id;
                        r_pend_status <= req_status;
                    end else begin
                        r_pend_valid <= 1'b0;
                    end
                end else if (req_valid) begin
                    r_state    <= ST_W0;
                    r_valid    <= 1'b1;
                    r_last     <= 1'b0;
                    r_data     <= MAGIC;
                    r_ip       <= req_ip;
                    r_dst_port <= req_port;
                    r_id       <= req_frame_id;
                    r_status   <= req_status;
                end else begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_data  <= 32'd0;
                end
            end else begin
                if (req_valid) begin
                    if (!r_pend_valid) begin
                        r_pend_valid  <= 1'b1;
                        r_pend_ip     <= req_ip;
                        r_pend_port   <= req_port;
                        r_pend_id     <= req_frame_id;
                        r_pend_status <= req_status;
                    end else if (r_drop_count != 16'hFFFF) begin
                        r_drop_count <= r_drop_count + 16'd1;
                    end
                end
                if (w_xfer) begin
                    case (r_state)
                        ST_W0: begin
                            r_state <= ST_W1;
                            r_data  <= {r_id, r_status};
                        end
                        ST_W1: begin
                            r_state <= ST_W2;
                            r_data  <= {16'd0, r_seq};
                            r_last  <= 1'b1;
                        end
                        default: begin
                            r_state <= r_state;
                        end
                    endcase
                end
            end
        end
    end

    assign udp_sink_valid      = r_valid;
    assign udp_sink_last       = r_last;
    assign udp_sink_data       = r_data;
    assign udp_sink_ip_address = r_ip;
    assign udp_sink_dst_port   = r_dst_port;
    assign udp_sink_src_port   = LOCAL_PORT;
    assign udp_sink_length     = 16'd12;
    assign udp_sink_error      = 4'b0000;
    assign drop_count          = r_drop_count;
    assign busy                = (r_state != ST_IDLE) | r_pend_valid;

endmodule

`default_nettype wire

// File: tb/tb_udp_ack_responder.sv
//------------------------------------------------------------------------------
// tb_udp_ack_responder
// Directed self-checking bench for udp_ack_responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_udp_ack_responder;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_ip = 32'd0;
    logic [15:0] req_port = 16'd0;
    logic [15:0] req_frame_id = 16'd0;
    logic [15:0] req_status = 16'd0;
    logic        udp_sink_ready = 1'b0;
    logic        udp_sink_valid;
    logic        udp_sink_last;
    logic [15:0] udp_sink_src_port;
    logic [15:0] udp_sink_dst_port;
    logic [31:0] udp_sink_ip_address;
    logic [15:0] udp_sink_length;
    logic [31:0] udp_sink_data;
    logic [3:0]  udp_sink_error;
    logic [15:0] drop_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] mon_data[$];
    logic        mon_last[$];
    logic [31:0] mon_ip[$];

    localparam logic [31:0] C_MAGIC = 32'h4C454441;

    udp_ack_responder dut (
        .clock              (clock),
        .resetn             (resetn),
        .req_valid          (req_valid),
        .req_ip             (req_ip),
        .req_port           (req_port),
        .req_frame_id       (req_frame_id),
        .req_status         (req_status),
        .udp_sink_valid     (udp_sink_valid),
        .udp_sink_last      (udp_sink_last),
        .udp_sink_ready     (udp_sink_ready),
        .udp_sink_src_port  (udp_sink_src_port),
        .udp_sink_dst_port  (udp_sink_dst_port),
        .udp_sink_ip_address(udp_sink_ip_address),
        .udp_sink_length    (udp_sink_length),
        .udp_sink_data      (udp_sink_data),
        .udp_sink_error     (udp_sink_error),
        .drop_count         (drop_count),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    // Words that will transfer on the coming rising edge
    always @(negedge clock) begin
        if (resetn && udp_sink_valid && udp_sink_ready) begin
            mon_data.push_back(udp_sink_data);
            mon_last.push_back(udp_sink_last);
            mon_ip.push_back(udp_sink_ip_address);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mon_clear();
        mon_data.delete();
        mon_last.delete();
        mon_ip.delete();
    endtask

    task automatic pulse_req(input logic [31:0] ip, input logic [15:0] port,
                             input logic [15:0] id, input logic [15:0] st);
        req_ip       = ip;
        req_port     = port;
        req_frame_id = id;
        req_status   = st;
        req_valid    = 1'b1;
        step();
        req_valid    = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        checks++; if (udp_sink_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", udp_sink_valid); end
        checks++; if (udp_sink_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", udp_sink_last); end
        checks++; if (udp_sink_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", udp_sink_data); end
        checks++; if (udp_sink_ip_address !== 32'd0 || udp_sink_dst_port !== 16'd0) begin errors++; $display("FAIL reset_addr: got ip %h port %h expected 0", udp_sink_ip_address, udp_sink_dst_port); end
        checks++; if (drop_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_drop_busy: got drop %h busy %b expected 0/0", drop_count, busy); end
        checks++; if (udp_sink_src_port !== 16'd26177 || udp_sink_length !== 16'd12 || udp_sink_error !== 4'd0) begin errors++; $display("FAIL reset_consts: got src %0d len %0d err %h expected 26177/12/0", udp_sink_src_port, udp_sink_length, udp_sink_error); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single();
        udp_sink_ready = 1'b1;
        mon_clear();
        pulse_req(32'h0A000002, 16'd1234, 16'h0007, 16'h0001);
        checks++; if (udp_sink_valid !== 1'b1 || udp_sink_data !== C_MAGIC || udp_sink_last !== 1'b0) begin errors++; $display("FAIL single_w0: got v%b d%h l%b expected v1 d%h l0", udp_sink_valid, udp_sink_data, udp_sink_last, C_MAGIC); end
        checks++; if (udp_sink_ip_address !== 32'h0A000002 || udp_sink_dst_port !== 16'd1234) begin errors++; $display("FAIL single_addr: got ip %h port %0d expected 0a000002/1234", udp_sink_ip_address, udp_sink_dst_port); end
        step();
        checks++; if (udp_sink_data !== 32'h00070001 || udp_sink_last !== 1'b0) begin errors++; $display("FAIL single_w1: got d%h l%b expected 00070001 l0", udp_sink_data, udp_sink_last); end
        step();
        checks++; if (udp_sink_data !== 32'h00000000 || udp_sink_last !== 1'b1) begin errors++; $display("FAIL single_w2: got d%h l%b expected 00000000 l1", udp_sink_data, udp_sink_last); end
        checks++; if (udp_sink_length !== 16'd12) begin errors++; $display("FAIL single_len: got %0d expected 12", udp_sink_length); end
        step();
        checks++; if (udp_sink_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got v%b busy%b expected 0/0", udp_sink_valid, busy); end
        checks++; if (mon_data.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", mon_data.size()); end
    endtask

    task automatic test_backpressure();
        logic        bp[6];
        logic [31:0] exp_w[3];
        logic [31:0] held;
        bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_w = '{C_MAGIC, 32'h00110022, 32'h00000001};
        udp_sink_ready = 1'b0;
        mon_clear();
        pulse_req(32'hC0A80105, 16'd5000, 16'h0011, 16'h0022);
        for (int i = 0; i < 6; i++) begin
            udp_sink_ready = bp[i];
            held = udp_sink_data;
            step();
            if (!bp[i]) begin
                checks++; if (udp_sink_data !== held || udp_sink_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got d%h v%b expected d%h v1", i, udp_sink_data, udp_sink_valid, held); end
            end
        end
        udp_sink_ready = 1'b0;
        checks++; if (udp_sink_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", udp_sink_valid); end
        checks++; if (mon_data.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", mon_data.size()); end
        for (int i = 0; i < 3 && i < mon_data.size(); i++) begin
            checks++; if (mon_data[i] !== exp_w[i] || mon_last[i] !== (i == 2)) begin errors++; $display("FAIL bp_word%0d: got %h l%b expected %h l%b", i, mon_data[i], mon_last[i], exp_w[i], (i == 2)); end
        end
    endtask

    task automatic test_burst();
        logic [31:0] exp_w[6];
        exp_w = '{C_MAGIC, 32'h01000200, 32'h00000002, C_MAGIC, 32'h01010201, 32'h00000003};
        udp_sink_ready = 1'b0;
        mon_clear();
        for (int i = 0; i < 4; i++) begin
            req_ip       = 32'h0A000000 + 32'(i);
            req_port     = 16'd100 + 16'(i);
            req_frame_id = 16'h0100 + 16'(i);
            req_status   = 16'h0200 + 16'(i);
            req_valid    = 1'b1;
            step();
        end
        req_valid = 1'b0;
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL burst_drops: got %0d expected 2", drop_count); end
        checks++; if (busy !== 1'b1 || udp_sink_data !== C_MAGIC || udp_sink_ip_address !== 32'h0A000000) begin errors++; $display("FAIL burst_active: got busy%b d%h ip%h expected 1/%h/0a000000", busy, udp_sink_data, udp_sink_ip_address, C_MAGIC); end
        udp_sink_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++; if (mon_data.size() != 6) begin errors++; $display("FAIL burst_count: got %0d expected 6", mon_data.size()); end
        for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
            checks++; if (mon_data[i] !== exp_w[i]) begin errors++; $display("FAIL burst_word%0d: got %h expected %h", i, mon_data[i], exp_w[i]); end
        end
        if (mon_ip.size() > 3) begin
            checks++; if (mon_ip[3] !== 32'h0A000001) begin errors++; $display("FAIL burst_pend_ip: got %h expected 0a000001", mon_ip[3]); end
        end
        checks++; if (udp_sink_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL burst_idle: got v%b busy%b expected 0/0", udp_sink_valid, busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[6];
        exp_w = '{C_MAGIC, 32'h0A0A0001, 32'h00000004, C_MAGIC, 32'h0B0B0002, 32'h00000005};
        udp_sink_ready = 1'b1;
        mon_clear();
        pulse_req(32'h0A000010, 16'd7, 16'h0A0A, 16'h0001);
        step();
        step();
        pulse_req(32'h0A000020, 16'd8, 16'h0B0B, 16'h0002);
        checks++; if (udp_sink_valid !== 1'b1 || udp_sink_data !== C_MAGIC || udp_sink_ip_address !== 32'h0A000020 || udp_sink_dst_port !== 16'd8) begin errors++; $display("FAIL b2b_next_w0: got v%b d%h ip%h port%0d expected v1 %h 0a000020 8", udp_sink_valid, udp_sink_data, udp_sink_ip_address, udp_sink_dst_port, C_MAGIC); end
        step();
        step();
        step();
        checks++; if (udp_sink_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", udp_sink_valid); end
        checks++; if (mon_data.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", mon_data.size()); end
        for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
            checks++; if (mon_data[i] !== exp_w[i]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, mon_data[i], exp_w[i]); end
        end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL b2b_drops: got %0d expected 2", drop_count); end
    endtask

    task automatic test_full_handoff();
        logic [31:0] exp_w[9];
        exp_w = '{C_MAGIC, 32'h00A10001, 32'h00000006, C_MAGIC, 32'h00B20002, 32'h00000007,
                  C_MAGIC, 32'h00C30003, 32'h00000008};
        udp_sink_ready = 1'b0;
        mon_clear();
        pulse_req(32'h0A0000A1, 16'd11, 16'h00A1, 16'h0001);
        pulse_req(32'h0A0000B2, 16'd12, 16'h00B2, 16'h0002);
        udp_sink_ready = 1'b1;
        step();
        step();
        pulse_req(32'h0A0000C3, 16'd13, 16'h00C3, 16'h0003);
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL handoff_drops: got %0d expected 2", drop_count); end
        checks++; if (udp_sink_data !== C_MAGIC || udp_sink_ip_address !== 32'h0A0000B2 || busy !== 1'b1) begin errors++; $display("FAIL handoff_active: got d%h ip%h busy%b expected %h 0a0000b2 1", udp_sink_data, udp_sink_ip_address, busy, C_MAGIC); end
        for (int i = 0; i < 6; i++) step();
        checks++; if (mon_data.size() != 9) begin errors++; $display("FAIL handoff_count: got %0d expected 9", mon_data.size()); end
        for (int i = 0; i < 9 && i < mon_data.size(); i++) begin
            checks++; if (mon_data[i] !== exp_w[i]) begin errors++; $display("FAIL handoff_word%0d: got %h expected %h", i, mon_data[i], exp_w[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL handoff_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_w[3];
        exp_w = '{C_MAGIC, 32'h0E0E0005, 32'h00000000};
        udp_sink_ready = 1'b1;
        pulse_req(32'h0A000030, 16'd9, 16'h0D0D, 16'h0004);
        step();
        checks++; if (udp_sink_valid !== 1'b1 || udp_sink_data !== 32'h0D0D0004) begin errors++; $display("FAIL rstmid_w1: got v%b d%h expected v1 0d0d0004", udp_sink_valid, udp_sink_data); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (udp_sink_valid !== 1'b0 || udp_sink_data !== 32'd0 || udp_sink_ip_address !== 32'd0) begin errors++; $display("FAIL rstmid_async: got v%b d%h ip%h expected 0/0/0", udp_sink_valid, udp_sink_data, udp_sink_ip_address); end
        checks++; if (drop_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got drop%0d busy%b expected 0/0", drop_count, busy); end
        @(negedge clock);
        resetn = 1'b1;
        step();
        mon_clear();
        pulse_req(32'h0A000040, 16'd10, 16'h0E0E, 16'h0005);
        checks++; if (udp_sink_data !== C_MAGIC) begin errors++; $display("FAIL rstmid_first: got %h expected %h", udp_sink_data, C_MAGIC); end
        step();
        step();
        step();
        checks++; if (mon_data.size() != 3) begin errors++; $display("FAIL rstmid_count: got %0d expected 3", mon_data.size()); end
        for (int i = 0; i < 3 && i < mon_data.size(); i++) begin
            checks++; if (mon_data[i] !== exp_w[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h expected %h", i, mon_data[i], exp_w[i]); end
        end
    endtask

    task automatic test_wrap();
        udp_sink_ready = 1'b1;
        force dut.r_seq = 16'hFFFF;
        step();
        release dut.r_seq;
        step();
        mon_clear();
        pulse_req(32'h0A000050, 16'd20, 16'h0F0F, 16'h0006);
        step();
        step();
        pulse_req(32'h0A000060, 16'd21, 16'h0F10, 16'h0007);
        step();
        step();
        step();
        checks++; if (mon_data.size() != 6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", mon_data.size()); end
        if (mon_data.size() == 6) begin
            checks++; if (mon_data[2] !== 32'h0000FFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected 0000ffff", mon_data[2]); end
            checks++; if (mon_data[5] !== 32'h00000000) begin errors++; $display("FAIL wrap_zero: got %h expected 00000000", mon_data[5]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_back_to_back();
        test_full_handoff();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/udp_ack_responder.md
UDP_ACK_RESPONDER -- requirements
Module: udp_ack_responder

Interface
REQ-001 Parameter LOCAL_PORT, default 16'd26177, is the UDP source port placed on every reply.
REQ-002 Parameter MAGIC, default 32'h4C454441, is reply word 0.
REQ-003 clock  input  1  system clock; the block uses one clock, shared with the Ethernet core and the panel writer.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  single-cycle pulse requesting one acknowledge packet.
REQ-006 req_ip  input  32  destination IPv4 address, sampled when req_valid=1.
REQ-007 req_port  input  16  destination UDP port, sampled when req_valid=1.
REQ-008 req_frame_id  input  16  frame identifier to echo, sampled when req_valid=1.
REQ-009 req_status  input  16  status code to echo, sampled when req_valid=1.
REQ-010 udp_sink_valid  output  1  reply word valid.
REQ-011 udp_sink_last  output  1  marks the final word of a reply.
REQ-012 udp_sink_ready  input  1  Ethernet core accepts the word.
REQ-013 udp_sink_src_port  output  16  always LOCAL_PORT.
REQ-014 udp_sink_dst_port  output  16  latched req_port.
REQ-015 udp_sink_ip_address  output  32  latched req_ip.
REQ-016 udp_sink_length  output  16  always 16'd12 (payload bytes).
REQ-017 udp_sink_data  output  32  reply word.
REQ-018 udp_sink_error  output  4  always 4'b0.
REQ-019 drop_count  output  16  saturating count of discarded requests.
REQ-020 busy  output  1  high when the state is not IDLE or the pending slot is full.

Function
REQ-021 The FSM SHALL have four states: IDLE, W0, W1 and W2.
REQ-022 A word SHALL transfer on a cycle where udp_sink_valid=1 and udp_sink_ready=1; while valid=1 and ready=0, data, last, ip and ports SHALL hold stable.
REQ-023 The word order SHALL be: W0 = MAGIC; W1 = {frame_id, status}; W2 = {16'b0, seq}. udp_sink_last SHALL be 1 only in W2.
REQ-024 udp_sink_valid SHALL be 1 exactly when the state is W0, W1 or W2.
REQ-025 Transitions: IDLE -> W0 when a request is available; W0 -> W1 and W1 -> W2 on transfer; W2 -> IDLE on transfer, or W2 -> W0 when the pending slot is full.
REQ-026 A request SHALL go to the active registers when the block is in IDLE, or is in W2 with a transfer, and the pending slot is empty; latency from req_valid to udp_sink_valid SHALL be 1 cycle.
REQ-027 A request arriving while a packet is active SHALL be stored in a one-entry pending slot if the slot is empty.
REQ-028 A request arriving while the slot is full SHALL be discarded and SHALL increment drop_count, which saturates at 16'hFFFF.
REQ-029 Simultaneous W2 completion and req_valid with a full slot: the pending entry becomes active, and the new request moves into the slot (no drop).
REQ-030 Simultaneous W2 completion and req_valid with an empty slot: the new request becomes active directly, with no idle cycle.
REQ-031 seq SHALL be a 16-bit register that increments by 1 on each W2 transfer and wraps from FFFF to 0000; W2 carries the pre-increment value.
REQ-032 The active request registers SHALL update only on entry to W0.

Reset
REQ-033 While resetn=0: state=IDLE, udp_sink_valid=0, udp_sink_last=0, udp_sink_data=0, dst_port=0, ip_address=0, pending slot empty, seq=0, drop_count=0, busy=0.
REQ-034 Reset asserted mid-packet SHALL abort the packet immediately; no partial packet is resumed after release.
REQ-035 The first request accepted after reset release SHALL produce seq=0.

Verification
REQ-036 Single request: req ip=0A000002, port=1234, id=0007, status=0001, ready held 1 -> three consecutive words 4C454441, 00070001, 00000000; last on the third word; length=12.
REQ-037 Backpressure: ready toggles 1,0,0,1,0,1 -> each word is held stable while ready=0, exactly 3 transfers occur, no duplicates.
REQ-038 Burst: four req pulses on consecutive cycles with ready=0 -> the first goes active, the second is pending, the third and fourth are dropped; drop_count=2; then ready=1 -> 6 words with seq 0 and 1.
REQ-039 Back-to-back: req_valid coincides with a W2 transfer, slot empty -> the next W0 follows in the next cycle; seq increments.
REQ-040 Reset mid-packet: assert resetn=0 during W1 -> valid drops asynchronously; after release, a new request yields seq=0 and MAGIC first.
REQ-041 Wrap: force 65536 packets -> seq reads FFFF, then 0000.
